// File: rtl/video_mem_arbiter.sv
// VRAM/OAM arbiter between CPU, PPU fetch port and the FF46 OAM DMA engine.
// Grants are combinational; read data returns one cycle later through a captured source select.
module video_mem_arbiter #(
  parameter int unsigned DMA_STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  input  logic [1:0]  ppu_mode,
  input  logic        ppu_rd,
  input  logic [15:0] ppu_addr,
  output logic [7:0]  ppu_rdata,
  output logic        dma_src_rd,
  output logic [15:0] dma_src_addr,
  input  logic [7:0]  dma_src_data,
  output logic [12:0] vram_addr,
  output logic        vram_we,
  output logic [7:0]  vram_wdata,
  input  logic [7:0]  vram_rdata,
  output logic [7:0]  oam_addr,
  output logic        oam_we,
  output logic [7:0]  oam_wdata,
  input  logic [7:0]  oam_rdata,
  output logic        dma_active
);

  localparam int unsigned PW = (DMA_STEP > 2) ? $clog2(DMA_STEP) : 1;
  localparam logic [PW-1:0] LAST_PHASE = PW'(DMA_STEP - 1);
  localparam logic [PW-1:0] WR_PHASE   = PW'(1);
  localparam logic [7:0]    LAST_BYTE  = 8'd159;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_XFER  = 2'd2
  } dma_state_t;

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_VRAM = 2'd1,
    RD_OAM  = 2'd2,
    RD_FF46 = 2'd3
  } rd_src_t;

  dma_state_t    state, state_nxt;
  logic [PW-1:0] phase, phase_nxt;
  logic [7:0]    byte_idx, byte_idx_nxt;
  logic [7:0]    src_hi;
  logic [7:0]    src_eff;
  logic [7:0]    ff46_q;
  rd_src_t       cpu_sel, cpu_sel_nxt;
  rd_src_t       ppu_sel, ppu_sel_nxt;

  logic cpu_vram_hit, cpu_oam_hit, cpu_ff46_hit;
  logic ppu_vram_hit, ppu_oam_hit;
  logic cpu_access, ff46_wr;
  logic dma_xfer, dma_oam_we;
  logic cpu_vram_gnt, cpu_oam_gnt, ppu_vram_gnt, ppu_oam_gnt;

  // Address decode
  always_comb begin
    cpu_vram_hit = (cpu_addr[15:13] == 3'b100);
    cpu_oam_hit  = (cpu_addr[15:8] == 8'hFE) && (cpu_addr[7:0] < 8'hA0);
    cpu_ff46_hit = (cpu_addr == 16'hFF46);
    ppu_vram_hit = (ppu_addr[15:13] == 3'b100);
    ppu_oam_hit  = (ppu_addr[15:8] == 8'hFE) && (ppu_addr[7:0] < 8'hA0);
    cpu_access   = cpu_rd || cpu_wr;
    ff46_wr      = cpu_wr && cpu_ff46_hit;
  end

  // DMA state and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      phase    <= '0;
      byte_idx <= '0;
    end else begin
      state    <= state_nxt;
      phase    <= phase_nxt;
      byte_idx <= byte_idx_nxt;
    end
  end

  // DMA next state; a FF46 write restarts from any state
  always_comb begin
    state_nxt    = state;
    phase_nxt    = phase;
    byte_idx_nxt = byte_idx;
    case (state)
      S_IDLE: begin
        phase_nxt    = '0;
        byte_idx_nxt = '0;
      end
      S_START: begin
        if (phase == LAST_PHASE) begin
          state_nxt    = S_XFER;
          phase_nxt    = '0;
          byte_idx_nxt = '0;
        end else begin
          phase_nxt = phase + PW'(1);
        end
      end
      S_XFER: begin
        if (phase == LAST_PHASE) begin
          phase_nxt = '0;
          if (byte_idx == LAST_BYTE) begin
            state_nxt    = S_IDLE;
            byte_idx_nxt = '0;
          end else begin
            byte_idx_nxt = byte_idx + 8'd1;
          end
        end else begin
          phase_nxt = phase + PW'(1);
        end
      end
      default: begin
        state_nxt    = S_IDLE;
        phase_nxt    = '0;
        byte_idx_nxt = '0;
      end
    endcase
    if (ff46_wr) begin
      state_nxt    = S_START;
      phase_nxt    = '0;
      byte_idx_nxt = '0;
    end
  end

  // DMA outputs; echo RAM sources map down onto WRAM
  always_comb begin
    dma_active   = (state != S_IDLE);
    dma_xfer     = (state == S_XFER);
    src_eff      = (src_hi >= 8'hE0) ? {src_hi[7:6], 1'b0, src_hi[4:0]} : src_hi;
    dma_src_rd   = dma_xfer && (phase == '0) && !rst;
    dma_src_addr = {src_eff, byte_idx};
    dma_oam_we   = dma_xfer && (phase == WR_PHASE) && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_hi <= 8'h00;
    end else if (ff46_wr) begin
      src_hi <= cpu_wdata;
    end
  end

  // Memory grants and port steering
  always_comb begin
    ppu_oam_gnt  = ppu_rd && ppu_oam_hit && ppu_mode[1] && !dma_active;
    cpu_oam_gnt  = cpu_access && cpu_oam_hit && !ppu_mode[1] && !dma_active;
    ppu_vram_gnt = ppu_rd && ppu_vram_hit && (ppu_mode == 2'd3);
    cpu_vram_gnt = cpu_access && cpu_vram_hit && (ppu_mode != 2'd3);

    oam_addr  = 8'h00;
    oam_wdata = cpu_wdata;
    oam_we    = 1'b0;
    if (dma_xfer) begin
      oam_addr  = byte_idx;
      oam_wdata = dma_src_data;
      oam_we    = dma_oam_we;
    end else if (ppu_oam_gnt) begin
      oam_addr = ppu_addr[7:0];
    end else if (cpu_oam_gnt) begin
      oam_addr = cpu_addr[7:0];
      oam_we   = cpu_wr && !rst;
    end

    vram_addr  = ppu_vram_gnt ? ppu_addr[12:0] : cpu_addr[12:0];
    vram_wdata = cpu_wdata;
    vram_we    = cpu_vram_gnt && cpu_wr && !rst;
  end

  // Read-source select for the next cycle
  always_comb begin
    cpu_sel_nxt = RD_NONE;
    ppu_sel_nxt = RD_NONE;
    if (cpu_rd) begin
      if (cpu_vram_gnt)      cpu_sel_nxt = RD_VRAM;
      else if (cpu_oam_gnt)  cpu_sel_nxt = RD_OAM;
      else if (cpu_ff46_hit) cpu_sel_nxt = RD_FF46;
    end
    if (ppu_rd) begin
      if (ppu_vram_gnt)     ppu_sel_nxt = RD_VRAM;
      else if (ppu_oam_gnt) ppu_sel_nxt = RD_OAM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_sel <= RD_NONE;
      ppu_sel <= RD_NONE;
      ff46_q  <= 8'h00;
    end else begin
      cpu_sel <= cpu_sel_nxt;
      ppu_sel <= ppu_sel_nxt;
      ff46_q  <= src_hi;
    end
  end

  // Late read data; losers and unmapped reads see 0xFF
  always_comb begin
    case (cpu_sel)
      RD_VRAM: cpu_rdata = vram_rdata;
      RD_OAM:  cpu_rdata = oam_rdata;
      RD_FF46: cpu_rdata = ff46_q;
      default: cpu_rdata = 8'hFF;
    endcase
    case (ppu_sel)
      RD_VRAM: ppu_rdata = vram_rdata;
      RD_OAM:  ppu_rdata = oam_rdata;
      default: ppu_rdata = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_video_mem_arbiter.sv
// Directed bench for video_mem_arbiter with VRAM/OAM memory and DMA source models.
module tb_video_mem_arbiter;

  localparam int unsigned DMA_STEP = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic        cpu_rd, cpu_wr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic [1:0]  ppu_mode;
  logic        ppu_rd;
  logic [15:0] ppu_addr;
  logic [7:0]  ppu_rdata;
  logic        dma_src_rd;
  logic [15:0] dma_src_addr;
  logic [7:0]  dma_src_data;
  logic [12:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata, vram_rdata;
  logic [7:0]  oam_addr;
  logic        oam_we;
  logic [7:0]  oam_wdata, oam_rdata;
  logic        dma_active;

  logic [7:0] vram_mem [0:8191];
  logic [7:0] oam_mem  [0:255];
  int src_mode;
  logic cnt_clr;
  int act_cnt, we_cnt;
  int n_checks, n_fail;

  always #5 clk = ~clk;

  video_mem_arbiter #(.DMA_STEP(DMA_STEP)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .ppu_mode(ppu_mode), .ppu_rd(ppu_rd), .ppu_addr(ppu_addr), .ppu_rdata(ppu_rdata),
    .dma_src_rd(dma_src_rd), .dma_src_addr(dma_src_addr), .dma_src_data(dma_src_data),
    .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata), .vram_rdata(vram_rdata),
    .oam_addr(oam_addr), .oam_we(oam_we), .oam_wdata(oam_wdata), .oam_rdata(oam_rdata),
    .dma_active(dma_active)
  );

  // Synchronous RAMs, DMA source and activity counters
  always @(posedge clk) begin
    if (vram_we) vram_mem[vram_addr] <= vram_wdata;
    vram_rdata <= vram_mem[vram_addr];
    if (oam_we) oam_mem[oam_addr] <= oam_wdata;
    oam_rdata <= oam_mem[oam_addr];
    if (dma_src_rd)
      dma_src_data <= (src_mode == 0) ? (dma_src_addr[7:0] ^ 8'hA5)
                                      : (dma_src_addr[7:0] + dma_src_addr[15:8]);
    if (cnt_clr) begin
      act_cnt <= 0;
      we_cnt  <= 0;
    end else begin
      if (dma_active) act_cnt <= act_cnt + 1;
      if (oam_we)     we_cnt  <= we_cnt + 1;
    end
  end

  task automatic bus_idle();
    cpu_rd  = 1'b0;
    cpu_wr  = 1'b0;
    ppu_rd  = 1'b0;
    cnt_clr = 1'b0;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bus_idle();
    cpu_addr = a; cpu_wdata = d; cpu_wr = 1'b1;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic cpu_read_start(input logic [15:0] a);
    @(negedge clk);
    bus_idle();
    cpu_addr = a; cpu_rd = 1'b1;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic test_reset();
    rst = 1'b1; bus_idle();
    ppu_mode = 2'd0; cpu_addr = 16'h0000; ppu_addr = 16'h0000; cpu_wdata = 8'h00;
    repeat (2) @(negedge clk);
    n_checks++; if (dma_active !== 1'b0) begin n_fail++; $display("FAIL reset_dma_active: got %b, expected 0", dma_active); end
    n_checks++; if (dma_src_rd !== 1'b0) begin n_fail++; $display("FAIL reset_dma_src_rd: got %b, expected 0", dma_src_rd); end
    n_checks++; if (oam_we !== 1'b0) begin n_fail++; $display("FAIL reset_oam_we: got %b, expected 0", oam_we); end
    n_checks++; if (cpu_rdata !== 8'hFF) begin n_fail++; $display("FAIL reset_cpu_rdata: got %h, expected ff", cpu_rdata); end
    n_checks++; if (ppu_rdata !== 8'hFF) begin n_fail++; $display("FAIL reset_ppu_rdata: got %h, expected ff", ppu_rdata); end
    cpu_addr = 16'h8000; cpu_wdata = 8'h12; cpu_wr = 1'b1;
    #1;
    n_checks++; if (vram_we !== 1'b0) begin n_fail++; $display("FAIL reset_vram_we: got %b, expected 0", vram_we); end
    @(negedge clk);
    rst = 1'b0; bus_idle();
    cpu_read_start(16'hFF46);
    n_checks++; if (cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_ff46: got %h, expected 00", cpu_rdata); end
  endtask

  task automatic test_cpu_hblank();
    @(negedge clk);
    bus_idle(); ppu_mode = 2'd0;
    cpu_addr = 16'h8010; cpu_wdata = 8'h5A; cpu_wr = 1'b1;
    #1;
    n_checks++; if (vram_we !== 1'b1) begin n_fail++; $display("FAIL hblank_vram_we: got %b, expected 1", vram_we); end
    n_checks++; if (vram_addr !== 13'h0010) begin n_fail++; $display("FAIL hblank_vram_addr: got %h, expected 0010", vram_addr); end
    n_checks++; if (vram_wdata !== 8'h5A) begin n_fail++; $display("FAIL hblank_vram_wdata: got %h, expected 5a", vram_wdata); end
    cpu_read_start(16'h8010);
    n_checks++; if (cpu_rdata !== 8'h5A) begin n_fail++; $display("FAIL hblank_vram_read: got %h, expected 5a", cpu_rdata); end
    @(negedge clk);
    cpu_addr = 16'hFE10; cpu_wdata = 8'h3C; cpu_wr = 1'b1;
    #1;
    n_checks++; if (oam_we !== 1'b1) begin n_fail++; $display("FAIL hblank_oam_we: got %b, expected 1", oam_we); end
    n_checks++; if (oam_addr !== 8'h10) begin n_fail++; $display("FAIL hblank_oam_addr: got %h, expected 10", oam_addr); end
    cpu_read_start(16'hFE10);
    n_checks++; if (cpu_rdata !== 8'h3C) begin n_fail++; $display("FAIL hblank_oam_read: got %h, expected 3c", cpu_rdata); end
    cpu_read_start(16'hC000);
    n_checks++; if (cpu_rdata !== 8'hFF) begin n_fail++; $display("FAIL unmapped_read: got %h, expected ff", cpu_rdata); end
  endtask

  task automatic test_draw_block();
    @(negedge clk);
    bus_idle(); ppu_mode = 2'd3;
    cpu_addr = 16'h8010; cpu_wdata = 8'h77; cpu_wr = 1'b1;
    #1;
    n_checks++; if (vram_we !== 1'b0) begin n_fail++; $display("FAIL draw_vram_we: got %b, expected 0", vram_we); end
    @(negedge clk);
    cpu_addr = 16'hFE00; cpu_wdata = 8'h22;
    #1;
    n_checks++; if (oam_we !== 1'b0) begin n_fail++; $display("FAIL draw_oam_we: got %b, expected 0", oam_we); end
    cpu_read_start(16'h8010);
    n_checks++; if (cpu_rdata !== 8'hFF) begin n_fail++; $display("FAIL draw_cpu_vram_read: got %h, expected ff", cpu_rdata); end
    cpu_read_start(16'hFE00);
    n_checks++; if (cpu_rdata !== 8'hFF) begin n_fail++; $display("FAIL draw_cpu_oam_read: got %h, expected ff", cpu_rdata); end
    @(negedge clk);
    ppu_addr = 16'h8010; ppu_rd = 1'b1;
    @(negedge clk);
    bus_idle();
    n_checks++; if (ppu_rdata !== 8'h5A) begin n_fail++; $display("FAIL draw_ppu_vram_read: got %h, expected 5a", ppu_rdata); end
  endtask

  task automatic test_full_dma();
    int first_rd, first_we, done_k;
    logic [15:0] first_addr;
    first_rd = 0; first_we = 0; done_k = 0; first_addr = 16'h0000;
    src_mode = 0;
    @(negedge clk);
    bus_idle(); ppu_mode = 2'd1;
    cnt_clr = 1'b1; cpu_addr = 16'hFF46; cpu_wdata = 8'hC1; cpu_wr = 1'b1;
    for (int k = 1; k <= 1000 && done_k == 0; k++) begin
      @(negedge clk);
      bus_idle();
      if (k == 1) begin
        n_checks++; if (dma_active !== 1'b1) begin n_fail++; $display("FAIL dma_active_rise: got %b, expected 1", dma_active); end
      end
      if (dma_src_rd && first_rd == 0) begin first_rd = k; first_addr = dma_src_addr; end
      if (oam_we && first_we == 0) first_we = k;
      if (!dma_active) done_k = k;
    end
    n_checks++; if (done_k !== 645) begin n_fail++; $display("FAIL dma_active_fall: got cycle %0d, expected 645", done_k); end
    n_checks++; if (first_rd !== 5) begin n_fail++; $display("FAIL dma_first_rd: got cycle %0d, expected 5", first_rd); end
    n_checks++; if (first_addr !== 16'hC100) begin n_fail++; $display("FAIL dma_first_addr: got %h, expected c100", first_addr); end
    n_checks++; if (first_we !== 6) begin n_fail++; $display("FAIL dma_first_we: got cycle %0d, expected 6", first_we); end
    n_checks++; if (act_cnt !== 644) begin n_fail++; $display("FAIL dma_active_len: got %0d, expected 644", act_cnt); end
    n_checks++; if (we_cnt !== 160) begin n_fail++; $display("FAIL dma_oam_we_count: got %0d, expected 160", we_cnt); end
    for (int i = 0; i < 160; i++) begin
      n_checks++;
      if (oam_mem[i] !== (8'(i) ^ 8'hA5)) begin
        n_fail++; $display("FAIL dma_oam[%0d]: got %h, expected %h", i, oam_mem[i], 8'(i) ^ 8'hA5);
      end
    end
  endtask

  task automatic test_dma_block();
    int done;
    src_mode = 0;
    cpu_write(16'hFF46, 8'hC1);
    repeat (20) @(negedge clk);
    ppu_mode = 2'd2;
    cpu_addr = 16'hFE05; cpu_rd = 1'b1; ppu_addr = 16'hFE05; ppu_rd = 1'b1;
    @(negedge clk);
    bus_idle();
    n_checks++; if (cpu_rdata !== 8'hFF) begin n_fail++; $display("FAIL dma_cpu_oam_read: got %h, expected ff", cpu_rdata); end
    n_checks++; if (ppu_rdata !== 8'hFF) begin n_fail++; $display("FAIL dma_ppu_oam_read: got %h, expected ff", ppu_rdata); end
    cpu_read_start(16'hFF46);
    n_checks++; if (cpu_rdata !== 8'hC1) begin n_fail++; $display("FAIL dma_ff46_read: got %h, expected c1", cpu_rdata); end
    ppu_mode = 2'd0;
    cpu_write(16'hFE03, 8'h00);
    done = 0;
    for (int k = 0; k < 1000 && done == 0; k++) begin
      @(negedge clk);
      if (!dma_active) done = 1;
    end
    n_checks++; if (done !== 1) begin n_fail++; $display("FAIL dma_block_timeout: got %0d, expected 1", done); end
    cpu_read_start(16'hFE05);
    n_checks++; if (cpu_rdata !== 8'hA0) begin n_fail++; $display("FAIL post_dma_read: got %h, expected a0", cpu_rdata); end
    cpu_read_start(16'hFE03);
    n_checks++; if (cpu_rdata !== 8'hA6) begin n_fail++; $display("FAIL dropped_cpu_oam_wr: got %h, expected a6", cpu_rdata); end
  endtask

  task automatic test_restart();
    int found, first_rd, done;
    logic [15:0] first_addr;
    src_mode = 1; ppu_mode = 2'd1;
    cpu_write(16'hFF46, 8'hC0);
    found = 0;
    for (int k = 0; k < 2000 && found == 0; k++) begin
      @(negedge clk);
      if (dma_src_rd && dma_src_addr == 16'hC032) found = 1;
    end
    n_checks++; if (found !== 1) begin n_fail++; $display("FAIL restart_byte50_timeout: got %0d, expected 1", found); end
    cpu_addr = 16'hFF46; cpu_wdata = 8'hE2; cpu_wr = 1'b1;
    first_rd = 0; first_addr = 16'h0000;
    for (int k = 1; k <= 20 && first_rd == 0; k++) begin
      @(negedge clk);
      bus_idle();
      if (k == 1) begin
        n_checks++; if (dma_active !== 1'b1) begin n_fail++; $display("FAIL restart_active: got %b, expected 1", dma_active); end
      end
      if (dma_src_rd) begin first_rd = k; first_addr = dma_src_addr; end
    end
    n_checks++; if (first_rd !== 5) begin n_fail++; $display("FAIL restart_first_rd: got cycle %0d, expected 5", first_rd); end
    n_checks++; if (first_addr !== 16'hC200) begin n_fail++; $display("FAIL restart_src_addr: got %h, expected c200", first_addr); end
    done = 0;
    for (int k = 0; k < 1000 && done == 0; k++) begin
      @(negedge clk);
      if (!dma_active) done = 1;
    end
    n_checks++; if (done !== 1) begin n_fail++; $display("FAIL restart_timeout: got %0d, expected 1", done); end
    for (int i = 0; i < 160; i++) begin
      n_checks++;
      if (oam_mem[i] !== (8'(i) + 8'hC2)) begin
        n_fail++; $display("FAIL restart_oam[%0d]: got %h, expected %h", i, oam_mem[i], 8'(i) + 8'hC2);
      end
    end
    cpu_read_start(16'hFF46);
    n_checks++; if (cpu_rdata !== 8'hE2) begin n_fail++; $display("FAIL restart_ff46_read: got %h, expected e2", cpu_rdata); end
  endtask

  task automatic test_reset_mid_dma();
    int found;
    src_mode = 0; ppu_mode = 2'd1;
    cpu_write(16'hFF46, 8'hC1);
    found = 0;
    for (int k = 0; k < 2000 && found == 0; k++) begin
      @(negedge clk);
      if (dma_src_rd && dma_src_addr == 16'hC150) found = 1;
    end
    n_checks++; if (found !== 1) begin n_fail++; $display("FAIL rstdma_byte80_timeout: got %0d, expected 1", found); end
    rst = 1'b1;
    #1;
    n_checks++; if (oam_we !== 1'b0) begin n_fail++; $display("FAIL rstdma_oam_we: got %b, expected 0", oam_we); end
    @(negedge clk);
    n_checks++; if (dma_active !== 1'b0) begin n_fail++; $display("FAIL rstdma_active: got %b, expected 0", dma_active); end
    rst = 1'b0;
    cpu_read_start(16'hFF46);
    n_checks++; if (cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL rstdma_ff46: got %h, expected 00", cpu_rdata); end
    repeat (10) @(negedge clk);
    n_checks++; if (dma_active !== 1'b0) begin n_fail++; $display("FAIL rstdma_stays_idle: got %b, expected 0", dma_active); end
    for (int i = 0; i < 160; i++) begin
      logic [7:0] exp;
      exp = (i < 80) ? (8'(i) ^ 8'hA5) : (8'(i) + 8'hC2);
      n_checks++;
      if (oam_mem[i] !== exp) begin
        n_fail++; $display("FAIL rstdma_oam[%0d]: got %h, expected %h", i, oam_mem[i], exp);
      end
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; src_mode = 0;
    cnt_clr = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; ppu_rd = 1'b0; rst = 1'b1;
    test_reset();
    test_cpu_hblank();
    test_draw_block();
    test_full_dma();
    test_dma_block();
    test_restart();
    test_reset_mid_dma();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/video_mem_arbiter.md
# video_mem_arbiter

Owns the VRAM and OAM single-port memories and arbitrates them between the CPU, the PPU fetch port and an internal OAM DMA engine. It also implements the FF46 DMA register. Every cycle it decides which requester drives each memory, blocks CPU access according to `ppu_mode`, and returns 0xFF to requesters that lose arbitration. It sits between the CPU bus decoder, the PPU's `PPU_ADDR`/`PPU_RD` port and the VRAM/OAM RAM macros.

## Interface
- `DMA_STEP`, default 4: clocks per DMA byte (one M-cycle). Legal values are 2 or more.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `cpu_addr` in 16: CPU address.
- `cpu_rd` in 1: CPU read strobe.
- `cpu_wr` in 1: CPU write strobe.
- `cpu_wdata` in 8: CPU write data.
- `cpu_rdata` out 8: CPU read data for VRAM, OAM and FF46, valid 1 cycle after `cpu_rd`.
- `ppu_mode` in 2: 0 = HBLANK, 1 = VBLANK, 2 = SCAN, 3 = DRAW.
- `ppu_rd` in 1: PPU read strobe.
- `ppu_addr` in 16: PPU read address.
- `ppu_rdata` out 8: PPU read data, valid 1 cycle after `ppu_rd`.
- `dma_src_rd` out 1: DMA source read strobe toward the system bus.
- `dma_src_addr` out 16: DMA source address.
- `dma_src_data` in 8: source data, valid 1 cycle after `dma_src_rd`.
- `vram_addr` out 13: VRAM address.
- `vram_we` out 1: VRAM write enable.
- `vram_wdata` out 8: VRAM write data.
- `vram_rdata` in 8: VRAM read data, synchronous with 1-cycle latency.
- `oam_addr` out 8: OAM address.
- `oam_we` out 1: OAM write enable.
- `oam_wdata` out 8: OAM write data.
- `oam_rdata` in 8: OAM read data, synchronous with 1-cycle latency.
- `dma_active` out 1: high while the DMA engine is in START or XFER.

## Operation
- **Address decode:**
  - VRAM = 0x8000–0x9FFF, with `vram_addr` = addr[12:0].
  - OAM = 0xFE00–0xFE9F, with `oam_addr` = addr[7:0].
  - FF46 is handled in this block.
  - Any other address is ignored here; `cpu_rdata` = 0xFF.
- **OAM priority:**
  1. DMA (in XFER).
  2. PPU, when `ppu_mode` is 2 or 3 and `ppu_addr` is in OAM.
  3. CPU, only when `ppu_mode` is 0 or 1 and `dma_active` = 0.
- **VRAM priority:**
  1. PPU, when `ppu_mode` = 3.
  2. CPU in all other modes.
- **Blocked requesters:** a blocked CPU write is dropped with no side effect. A blocked CPU read, or any PPU OAM read while `dma_active` = 1, returns 0xFF.
- **Read-data path:** a read-source select register captures which source won at the request cycle and steers the 1-cycle-late `*_rdata`.
- **DMA states (IDLE, START, XFER):**
  - IDLE -> START on a CPU write to FF46. The value is latched as `src_hi` and also reads back on FF46.
  - START lasts `DMA_STEP` cycles, then -> XFER with byte index i = 0.
  - XFER, per byte, phase counter p from 0 to `DMA_STEP`−1:
    - p = 0: `dma_src_rd` = 1, `dma_src_addr` = {`src_hi`', i}.
    - p = 1: `oam_we` = 1, `oam_addr` = i, `oam_wdata` = `dma_src_data`.
  - After i = 159 at p = `DMA_STEP`−1 -> IDLE.
- **Source remap:** `src_hi`' = `src_hi` with bit 5 cleared when `src_hi` ≥ 0xE0 (echo maps to WRAM, so E0 reads from C0).
- **Restart:** a FF46 write in START or XFER restarts DMA: new `src_hi`, state START, i = 0, p = 0. The old transfer is abandoned immediately.
- **Counter widths:** i is 8 bits and compared against 159; p is `$clog2(DMA_STEP)` bits. Neither counter ever wraps past its terminal value.
- **`ppu_mode` changes** take effect on the very cycle they are presented; no request is held over or queued.

## Timing
- **Reset values:**
  - State IDLE, FF46 = 0x00.
  - `dma_active` = 0, `dma_src_rd` = 0.
  - `vram_we` = 0, `oam_we` = 0.
  - `cpu_rdata` = 0xFF, `ppu_rdata` = 0xFF.
  - Read-source select = none.
- **Reset mid-DMA:** returns to IDLE the next edge with no further `oam_we`.
- **DMA timing:**
  - A FF46 write sampled at edge T sets `dma_active` = 1 from cycle T+1.
  - The first `dma_src_rd` is at cycle T+1+`DMA_STEP`.
  - The first `oam_we` is one cycle later.
  - `dma_active` falls after 161·`DMA_STEP` cycles, i.e. it is low at cycle T+1+161·`DMA_STEP`.
- **Write and read latency:** CPU and PPU writes reach the memory in the same cycle (combinational grant). Read data is presented exactly 1 cycle after the strobe.
- **Simultaneous events:**
  - A CPU OAM write in the same cycle as the DMA `oam_we` is dropped.
  - A CPU FF46 write on the last DMA byte restarts; byte 159 of the old transfer is still written that cycle.
  - A CPU read of FF46 during DMA returns the latched value.

## Test plan
- **CPU access in HBLANK:** `ppu_mode`=0, CPU writes 0x5A to 0x8010, then reads it. Required: `vram_we` asserted with `vram_addr`=0x010, and `cpu_rdata`=0x5A one cycle after `cpu_rd`.
- **CPU blocked in DRAW:** `ppu_mode`=3, CPU writes 0x8010 and 0xFE00. Required: no `vram_we`, no `oam_we`, CPU reads return 0xFF. The PPU reading 0x8010 gets the memory value.
- **Full DMA:** FF46←0xC1 with `DMA_STEP`=4 and a source model returning (addr & 0xFF)^0xA5. Required: OAM[i] = i^0xA5 for i = 0..159, exactly 160 `oam_we` pulses, `dma_active` high for 644 cycles.
- **DMA blocking:** during DMA, CPU reads 0xFE05 -> 0xFF; PPU reads 0xFE05 in `ppu_mode`=2 -> 0xFF. After DMA, a CPU read in HBLANK returns the DMA'd value.
- **Restart and echo remap:** FF46←0xC0, then FF46←0xE2 at byte 50. Required: the source restarts at 0xC200, i = 0, and the final OAM holds only the 0xC2xx data.
- **Reset mid-DMA:** `rst` at byte 80. Required: the next cycle has `dma_active`=0 and FF46 reads 0x00; OAM[80..159] are untouched.
